ysyx_040066_mem_resp: RTL and testbench
=======================================

YSYX_040066_MEM_RESP -- requirements
Module: ysyx_040066_mem_resp

Interface
REQ-001 SHALL have parameter BASE, default 64'h8000_0000: byte address of memory word 0.
REQ-002 SHALL have parameter DEPTH, default 8192: number of 64-bit words; must be a multiple of 8.
REQ-003 SHALL have parameter LAT, default 2 (1..15): cycles from request acceptance to first response.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port rd_req, input, 1 bit: read request, held by initiator until final beat.
REQ-007 SHALL have port rd_burst, input, 1 bit: 1 = 8-beat line read, 0 = single beat.
REQ-008 SHALL have port rd_len, input, 3 bits: single-read size code, 0..3 = 1/2/4/8 bytes.
REQ-009 SHALL have port rd_addr, input, 64 bits: read byte address.
REQ-010 SHALL have port rd_ready, output, 1 bit: read beat valid, one-cycle pulse per beat.
REQ-011 SHALL have port rd_last, output, 1 bit: final beat, asserted with rd_ready.
REQ-012 SHALL have port rd_err, output, 1 bit: beat error, asserted with rd_ready.
REQ-013 SHALL have port rd_data, output, 64 bits: beat data.
REQ-014 SHALL have ports wr_req (input, 1 bit), wr_burst (input, 1 bit), wr_len (input, 3 bits), wr_mask (input, 8 bits), wr_addr (input, 64 bits), wr_data (input, 512 bits): write request, with the same hold rule as rd_req.
REQ-015 SHALL have ports wr_ready (output, 1 bit) and wr_err (output, 1 bit): one-cycle write completion pulse and its error flag.

Function
REQ-016 SHALL implement states IDLE, RD_WAIT, RD_BEAT, WR_WAIT, WR_DONE, GAP.
- IDLE with wr_req=1 -> WR_WAIT; else with rd_req=1 -> RD_WAIT.
- Write wins when both requests are high.
REQ-017 SHALL latch address, burst, len and mask on acceptance, and ignore request inputs until the state returns to IDLE.
REQ-018 SHALL hold WR_WAIT/RD_WAIT for LAT-1 cycles, so the first response pulse appears LAT cycles after the acceptance edge.
REQ-019 Address range: in-range iff BASE <= addr < BASE+DEPTH*8; word index = (addr-BASE)>>3.
REQ-020 Burst read: addr[5:0] SHALL be treated as 0; 8 beats on consecutive cycles; beat i returns word (line base + i); rd_last on beat 7 only.
REQ-021 Single read: one beat returning the doubleword containing addr, unshifted; rd_last=1.
REQ-022 rd_err SHALL be set on every beat whose address is out of range, with rd_data=0.
- rd_err SHALL also be set on a single read with rd_len>3.
REQ-023 Burst write: wr_data[64*i+63:64*i] SHALL go to word (line base + i), all bytes, in the WR_DONE cycle.
REQ-024 Single write: wr_data[63:0] SHALL go to the word containing addr, per byte lane where wr_mask[b]=1.
- wr_len is ignored for data placement.
- wr_len>3 SHALL give wr_err=1 and no write.
REQ-025 Out-of-range write: memory unchanged, wr_err=1.
REQ-026 wr_ready SHALL pulse exactly one cycle, in WR_DONE; the memory update is visible to any read accepted afterwards.
REQ-027 After the final read beat or WR_DONE, SHALL spend one cycle in GAP ignoring requests, then return to IDLE.
- The initiator drops its request in the cycle after completion.
REQ-028 rd_ready, rd_last, rd_err and wr_ready, wr_err SHALL be 0 in every state except the corresponding beat/done cycle.
- rd_data is don't-care outside beats but SHALL be driven to 0.
REQ-029 Memory array SHALL be a registered DEPTH x 64 array; reads may be registered internally but must meet REQ-018 timing.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE and all outputs to 0 (rd_data=0), regardless of clock.
REQ-031 Reset mid-burst or mid-write SHALL abandon the transaction; a write not yet in WR_DONE SHALL leave memory unchanged.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 First request SHALL be acceptable on the first rising edge after rst returns to 1.

Verification
REQ-034 Burst write then read: write line 0x8000_0040 with words 0x11..0x88, LAT=2; then rd_burst at 0x8000_0047 -> wr_ready 2 cycles after acceptance; 8 rd_ready beats data 0x11..0x88, rd_last on beat 8 only, rd_err=0.
REQ-035 Masked single write: word at 0x8000_0008 = 0xFFFF_FFFF_FFFF_FFFF; write 0x0123_4567_89AB_CDEF with mask 8'h0F; read it -> 0xFFFF_FFFF_89AB_CDEF.
REQ-036 Out of range: single read at 0x0000_1000 -> one beat, rd_err=1, rd_data=0. Burst write at BASE+DEPTH*8 -> wr_err=1, memory unchanged.
REQ-037 Simultaneous rd_req and wr_req to the same word, old value A, new value B -> write served first; read returns B.
- Request held through GAP -> no duplicate service.
REQ-038 Async reset at burst beat 3 -> outputs 0 within the same cycle, state IDLE. New single read accepted on the first edge after release -> correct data after LAT.

Source files
------------

// File: rtl/ysyx_040066_mem_resp.sv
// ysyx_040066_mem_resp: fixed-latency word memory answering single/burst read and write requests
module ysyx_040066_mem_resp #(
  parameter logic [63:0] BASE = 64'h8000_0000,
  parameter int DEPTH = 8192,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_req,
  input  logic         rd_burst,
  input  logic [2:0]   rd_len,
  input  logic [63:0]  rd_addr,
  output logic         rd_ready,
  output logic         rd_last,
  output logic         rd_err,
  output logic [63:0]  rd_data,
  input  logic         wr_req,
  input  logic         wr_burst,
  input  logic [2:0]   wr_len,
  input  logic [7:0]   wr_mask,
  input  logic [63:0]  wr_addr,
  input  logic [511:0] wr_data,
  output logic         wr_ready,
  output logic         wr_err
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [63:0] SIZE = 64'(DEPTH) * 64'd8;
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_WAIT, WR_DONE, GAP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [63:0] addr_q;
  logic burst_q;
  logic [2:0] len_q;
  logic [7:0] mask_q;
  logic [511:0] data_q;
  logic [63:0] mem [DEPTH];
  logic [63:0] line, baddr;
  logic [2:0] bidx;
  logic rd_bad, rd_end, wr_go, wr_bad;
  function automatic logic in_rng(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < SIZE);
  endfunction
  function automatic logic [IW-1:0] widx(input logic [63:0] a);
    return IW'((a - BASE) >> 3);
  endfunction
  // cnt holds the last emitted beat while in RD_BEAT, so the next beat is cnt+1
  always_comb begin
    line = {addr_q[63:6], 6'd0};
    bidx = state == RD_BEAT ? cnt[2:0] + 3'd1 : 3'd0;
    baddr = burst_q ? line + {58'd0, bidx, 3'd0} : addr_q;
    rd_bad = !in_rng(baddr) || (!burst_q && len_q > 3'd3);
    rd_end = !burst_q || cnt == 4'd7;
    wr_go = state == WR_WAIT && cnt == 4'd0;
    wr_bad = !in_rng(burst_q ? line : addr_q) || (!burst_q && len_q > 3'd3);
  end
  // commit write data on the edge entering WR_DONE; the array has no reset
  always_ff @(posedge clk)
    if (wr_go && !wr_bad)
      for (int i = 0; i < 8; i++)
        if (burst_q) mem[widx(line) + IW'(i)] <= data_q[64*i +: 64];
        else if (mask_q[i]) mem[widx(addr_q)][8*i +: 8] <= data_q[8*i +: 8];
  // request sequencing with registered response outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      burst_q <= 1'b0;
      len_q <= '0;
      mask_q <= '0;
      data_q <= '0;
      rd_ready <= 1'b0;
      rd_last <= 1'b0;
      rd_err <= 1'b0;
      rd_data <= '0;
      wr_ready <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      rd_ready <= 1'b0;
      rd_last <= 1'b0;
      rd_err <= 1'b0;
      rd_data <= '0;
      wr_ready <= 1'b0;
      wr_err <= 1'b0;
      case (state)
        IDLE:
          if (wr_req) begin
            state <= WR_WAIT;
            cnt <= 4'(LAT - 1);
            addr_q <= wr_addr;
            burst_q <= wr_burst;
            len_q <= wr_len;
            mask_q <= wr_mask;
            data_q <= wr_data;
          end else if (rd_req) begin
            state <= RD_WAIT;
            cnt <= 4'(LAT - 1);
            addr_q <= rd_addr;
            burst_q <= rd_burst;
            len_q <= rd_len;
          end
        RD_WAIT, RD_BEAT:
          if (state == RD_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
          else if (state == RD_BEAT && rd_end) state <= GAP;
          else begin
            state <= RD_BEAT;
            cnt <= {1'b0, bidx};
            rd_ready <= 1'b1;
            rd_last <= !burst_q || bidx == 3'd7;
            rd_err <= rd_bad;
            rd_data <= rd_bad ? 64'd0 : mem[widx(baddr)];
          end
        WR_WAIT:
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            state <= WR_DONE;
            wr_ready <= 1'b1;
            wr_err <= wr_bad;
          end
        WR_DONE: state <= GAP;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ysyx_040066_mem_resp.sv
// tb_ysyx_040066_mem_resp: directed plus random checks against a word-array reference model
module tb_ysyx_040066_mem_resp;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int DEPTH = 64;
  localparam int LAT = 2;
  logic clk, rst;
  logic rd_req, rd_burst, rd_ready, rd_last, rd_err;
  logic [2:0] rd_len;
  logic [63:0] rd_addr, rd_data;
  logic wr_req, wr_burst, wr_ready, wr_err;
  logic [2:0] wr_len;
  logic [7:0] wr_mask;
  logic [63:0] wr_addr;
  logic [511:0] wr_data;
  int compared = 0;
  int mismatched = 0;
  logic [63:0] model [DEPTH];

  ysyx_040066_mem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_burst(rd_burst), .rd_len(rd_len), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_last(rd_last), .rd_err(rd_err), .rd_data(rd_data),
    .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic inr(input logic [63:0] a);
    return a >= BASE && a < BASE + 64'(DEPTH) * 64'd8;
  endfunction

  function automatic int wi(input logic [63:0] a);
    return int'((a - BASE) / 64'd8);
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom();
    return d;
  endfunction

  task automatic do_wr(input logic b, input logic [2:0] len, input logic [7:0] m,
                       input logic [63:0] a, input logic [511:0] d, input int exp_k);
    int k;
    logic e;
    logic [63:0] ln, w;
    wr_req = 1'b1; wr_burst = b; wr_len = len; wr_mask = m; wr_addr = a; wr_data = d;
    k = 0;
    do begin @(negedge clk); k++; end while (!wr_ready && k < 40);
    chk("wr_latency", 64'(k), 64'(exp_k));
    ln = a & ~64'h3f;
    e = b ? !inr(ln) : (len > 3'd3 || !inr(a));
    chk("wr_err", 64'(wr_err), 64'(e));
    chk("wr_rd_quiet", 64'(rd_ready), 64'd0);
    if (!e) begin
      if (b) for (int i = 0; i < 8; i++) model[wi(ln) + i] = d[64*i +: 64];
      else begin
        w = model[wi(a)];
        for (int j = 0; j < 8; j++) if (m[j]) w[8*j +: 8] = d[8*j +: 8];
        model[wi(a)] = w;
      end
    end
    @(negedge clk);
    wr_req = 1'b0;
    chk("wr_single_pulse", 64'(wr_ready), 64'd0);
  endtask

  task automatic do_rd(input logic b, input logic [2:0] len, input logic [63:0] a,
                       input int exp_k, output logic [63:0] last);
    int k, n;
    logic e;
    logic [63:0] ba, ed;
    rd_req = 1'b1; rd_burst = b; rd_len = len; rd_addr = a;
    k = 0;
    do begin @(negedge clk); k++; end while (!rd_ready && k < 40);
    chk("rd_latency", 64'(k), 64'(exp_k));
    n = b ? 8 : 1;
    last = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      ba = b ? (a & ~64'h3f) + 64'(8 * i) : a;
      e = !inr(ba) || (!b && len > 3'd3);
      ed = 64'd0;
      if (!e) ed = model[wi(ba)];
      chk($sformatf("rd_ready[%0d]", i), 64'(rd_ready), 64'd1);
      chk($sformatf("rd_data[%0d]", i), rd_data, ed);
      chk($sformatf("rd_err[%0d]", i), 64'(rd_err), 64'(e));
      chk($sformatf("rd_last[%0d]", i), 64'(rd_last), 64'(i == n - 1));
      last = rd_data;
    end
    @(negedge clk);
    rd_req = 1'b0;
    chk("rd_no_extra_beat", 64'(rd_ready), 64'd0);
  endtask

  initial begin
    logic [511:0] d;
    logic [63:0] a, x;
    int k;
    rst = 1'b0;
    rd_req = 1'b0; rd_burst = 1'b0; rd_len = '0; rd_addr = '0;
    wr_req = 1'b0; wr_burst = 1'b0; wr_len = '0; wr_mask = '0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_rd_ready", 64'(rd_ready), 64'd0);
    chk("reset_rd_last", 64'(rd_last), 64'd0);
    chk("reset_rd_err", 64'(rd_err), 64'd0);
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_wr_ready", 64'(wr_ready), 64'd0);
    chk("reset_wr_err", 64'(wr_err), 64'd0);
    rst = 1'b1;
    for (int l = 0; l < DEPTH / 8; l++) begin
      do_wr(1'b1, 3'd3, 8'hff, BASE + 64'(64 * l), rnd512(), LAT + 1);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) d[64*i +: 64] = 64'(8'h11 * (i + 1));
    do_wr(1'b1, 3'd0, 8'h00, BASE + 64'h40, d, LAT + 1);
    @(negedge clk);
    do_rd(1'b1, 3'd0, BASE + 64'h47, LAT + 1, x);
    chk("burst_last_word", x, 64'h88);
    @(negedge clk);
    do_wr(1'b0, 3'd3, 8'hff, BASE + 64'h8, {448'd0, 64'hFFFF_FFFF_FFFF_FFFF}, LAT + 1);
    @(negedge clk);
    do_wr(1'b0, 3'd3, 8'h0f, BASE + 64'h8, {448'd0, 64'h0123_4567_89AB_CDEF}, LAT + 1);
    @(negedge clk);
    do_rd(1'b0, 3'd3, BASE + 64'h8, LAT + 1, x);
    chk("masked_write", x, 64'hFFFF_FFFF_89AB_CDEF);
    @(negedge clk);
    do_rd(1'b0, 3'd3, 64'h1000, LAT + 1, x);
    @(negedge clk);
    do_wr(1'b1, 3'd3, 8'hff, BASE + 64'(DEPTH * 8), rnd512(), LAT + 1);
    @(negedge clk);
    do_rd(1'b1, 3'd3, BASE + 64'((DEPTH - 8) * 8), LAT + 1, x);
    @(negedge clk);
    do_rd(1'b0, 3'd5, BASE + 64'h10, LAT + 1, x);
    @(negedge clk);
    do_wr(1'b0, 3'd4, 8'hff, BASE + 64'h10, rnd512(), LAT + 1);
    @(negedge clk);
    do_rd(1'b0, 3'd3, BASE + 64'h10, LAT + 1, x);
    @(negedge clk);
    a = BASE + 64'h100;
    rd_req = 1'b1; rd_burst = 1'b0; rd_len = 3'd3; rd_addr = a;
    d = rnd512();
    do_wr(1'b0, 3'd3, 8'hff, a, d, LAT + 1);
    do_rd(1'b0, 3'd3, a, LAT + 2, x);
    chk("write_wins", x, d[63:0]);
    @(negedge clk);
    rd_req = 1'b1; rd_burst = 1'b1; rd_len = 3'd0; rd_addr = BASE + 64'h80;
    k = 0;
    do begin @(negedge clk); k++; end while (!rd_ready && k < 40);
    chk("rst_burst_start", 64'(k), 64'(LAT + 1));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_rd_ready", 64'(rd_ready), 64'd0);
    chk("async_rst_rd_data", rd_data, 64'd0);
    chk("async_rst_rd_last", 64'(rd_last), 64'd0);
    chk("async_rst_rd_err", 64'(rd_err), 64'd0);
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_rd(1'b0, 3'd3, BASE + 64'h108, LAT + 1, x);
    @(negedge clk);
    wr_req = 1'b1; wr_burst = 1'b0; wr_len = 3'd3; wr_mask = 8'hff;
    wr_addr = BASE + 64'h110; wr_data = rnd512();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("async_rst_wr_ready", 64'(wr_ready), 64'd0);
    wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_rd(1'b0, 3'd3, BASE + 64'h110, LAT + 1, x);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      a = ($urandom_range(0, 7) == 0) ? BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 255))
                                     : BASE + 64'($urandom_range(0, DEPTH * 8 - 1));
      if ($urandom_range(0, 1) == 1)
        do_wr(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 8'($urandom()), a, rnd512(), LAT + 1);
      else
        do_rd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), a, LAT + 1, x);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
